// File: rtl/ul8_mem_pkg.sv
// Shared constants and types for the data-RAM arbiter slice.
package ul8_mem_pkg;

  localparam int unsigned ADDR_W     = 5;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned MAX_LOCK   = 8;
  localparam int unsigned LOCK_CNT_W = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_A    = 2'd1,
    OWN_B    = 2'd2
  } owner_t;

endpackage

// File: rtl/ram_arb_pick.sv
// Combinational grant decision: lock override first, round-robin otherwise.
module ram_arb_pick
  import ul8_mem_pkg::*;
#(
  parameter int unsigned LOCK_MAX = ul8_mem_pkg::MAX_LOCK
) (
  input  logic                  a_req_i,
  input  logic                  b_req_i,
  input  owner_t                lock_owner_i,
  input  logic [LOCK_CNT_W-1:0] lock_cnt_i,
  input  owner_t                last_winner_i,
  output logic                  a_gnt_o,
  output logic                  b_gnt_o,
  output logic                  force_rel_o
);

  logic at_max;
  assign at_max = (lock_cnt_i == LOCK_CNT_W'(LOCK_MAX));

  always_comb begin
    a_gnt_o     = 1'b0;
    b_gnt_o     = 1'b0;
    force_rel_o = 1'b0;
    if (lock_owner_i == OWN_A && a_req_i) begin
      // An exhausted lock yields to a waiting peer for exactly this cycle.
      if (at_max && b_req_i) begin
        b_gnt_o     = 1'b1;
        force_rel_o = 1'b1;
      end else begin
        a_gnt_o = 1'b1;
      end
    end else if (lock_owner_i == OWN_B && b_req_i) begin
      if (at_max && a_req_i) begin
        a_gnt_o     = 1'b1;
        force_rel_o = 1'b1;
      end else begin
        b_gnt_o = 1'b1;
      end
    end else if (a_req_i && b_req_i) begin
      if (last_winner_i == OWN_A) b_gnt_o = 1'b1;
      else                        a_gnt_o = 1'b1;
    end else begin
      a_gnt_o = a_req_i;
      b_gnt_o = b_req_i;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of the single-port 32x8 data RAM, with bounded
// burst locking and one-cycle response routing back to the granted port.
module ram_arbiter #(
  parameter int unsigned ADDR_W   = ul8_mem_pkg::ADDR_W,
  parameter int unsigned DATA_W   = ul8_mem_pkg::DATA_W,
  parameter int unsigned MAX_LOCK = ul8_mem_pkg::MAX_LOCK
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic              a_lock,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  input  logic              b_lock,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_value_in,
  output logic              ram_write,
  input  logic [DATA_W-1:0] ram_value_out
);

  import ul8_mem_pkg::*;

  owner_t                lock_owner_q, lock_owner_d;
  logic [LOCK_CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  owner_t                last_winner_q, last_winner_d;
  owner_t                resp_owner_q, resp_owner_d;

  logic pick_a, pick_b, force_rel;

  ram_arb_pick #(
    .LOCK_MAX (MAX_LOCK)
  ) u_pick (
    .a_req_i       (a_req),
    .b_req_i       (b_req),
    .lock_owner_i  (lock_owner_q),
    .lock_cnt_i    (lock_cnt_q),
    .last_winner_i (last_winner_q),
    .a_gnt_o       (pick_a),
    .b_gnt_o       (pick_b),
    .force_rel_o   (force_rel)
  );

  assign a_gnt = pick_a & ~rst;
  assign b_gnt = pick_b & ~rst;

  always_comb begin
    ram_address  = '0;
    ram_value_in = '0;
    ram_write    = 1'b0;
    if (a_gnt) begin
      ram_address  = a_addr;
      ram_value_in = a_wdata;
      ram_write    = a_we;
    end else if (b_gnt) begin
      ram_address  = b_addr;
      ram_value_in = b_wdata;
      ram_write    = b_we;
    end
  end

  always_comb begin
    lock_owner_d  = lock_owner_q;
    lock_cnt_d    = lock_cnt_q;
    last_winner_d = last_winner_q;
    resp_owner_d  = OWN_NONE;
    if (a_gnt) begin
      last_winner_d = OWN_A;
      resp_owner_d  = OWN_A;
    end else if (b_gnt) begin
      last_winner_d = OWN_B;
      resp_owner_d  = OWN_B;
    end
    case (lock_owner_q)
      OWN_NONE: begin
        if (a_gnt && a_lock) begin
          lock_owner_d = OWN_A;
          lock_cnt_d   = LOCK_CNT_W'(1);
        end else if (b_gnt && b_lock) begin
          lock_owner_d = OWN_B;
          lock_cnt_d   = LOCK_CNT_W'(1);
        end
      end
      OWN_A: begin
        if (!a_req || force_rel || (a_gnt && !a_lock)) begin
          lock_owner_d = OWN_NONE;
          lock_cnt_d   = '0;
        end else if (a_gnt && lock_cnt_q != LOCK_CNT_W'(MAX_LOCK)) begin
          lock_cnt_d = lock_cnt_q + LOCK_CNT_W'(1);
        end
      end
      OWN_B: begin
        if (!b_req || force_rel || (b_gnt && !b_lock)) begin
          lock_owner_d = OWN_NONE;
          lock_cnt_d   = '0;
        end else if (b_gnt && lock_cnt_q != LOCK_CNT_W'(MAX_LOCK)) begin
          lock_cnt_d = lock_cnt_q + LOCK_CNT_W'(1);
        end
      end
      default: begin
        lock_owner_d = OWN_NONE;
        lock_cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_owner_q  <= OWN_NONE;
      lock_cnt_q    <= '0;
      last_winner_q <= OWN_B;
      resp_owner_q  <= OWN_NONE;
    end else begin
      lock_owner_q  <= lock_owner_d;
      lock_cnt_q    <= lock_cnt_d;
      last_winner_q <= last_winner_d;
      resp_owner_q  <= resp_owner_d;
    end
  end

  assign a_rvalid = (resp_owner_q == OWN_A);
  assign b_rvalid = (resp_owner_q == OWN_B);
  assign a_rdata  = a_rvalid ? ram_value_out : '0;
  assign b_rdata  = b_rvalid ? ram_value_out : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter with a behavioural RAM and reference model.
module tb_ram_arbiter;

  localparam int MAXL = 8;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, tb_clear;
  logic       a_req, a_we, a_lock, b_req, b_we, b_lock;
  logic [4:0] a_addr, b_addr;
  logic [7:0] a_wdata, b_wdata;
  logic       a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [7:0] a_rdata, b_rdata;
  logic [4:0] ram_address;
  logic [7:0] ram_value_in, ram_value_out;
  logic       ram_write;

  ram_arbiter #(
    .ADDR_W   (5),
    .DATA_W   (8),
    .MAX_LOCK (MAXL)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .a_req         (a_req),
    .a_we          (a_we),
    .a_addr        (a_addr),
    .a_wdata       (a_wdata),
    .a_lock        (a_lock),
    .a_gnt         (a_gnt),
    .a_rvalid      (a_rvalid),
    .a_rdata       (a_rdata),
    .b_req         (b_req),
    .b_we          (b_we),
    .b_addr        (b_addr),
    .b_wdata       (b_wdata),
    .b_lock        (b_lock),
    .b_gnt         (b_gnt),
    .b_rvalid      (b_rvalid),
    .b_rdata       (b_rdata),
    .ram_address   (ram_address),
    .ram_value_in  (ram_value_in),
    .ram_write     (ram_write),
    .ram_value_out (ram_value_out)
  );

  // Behavioural single-port RAM: registered read, write echoes the written value.
  logic [7:0] ram [32];
  always @(posedge clk) begin
    if (tb_clear) begin
      for (int i = 0; i < 32; i++) ram[i] <= 8'h00;
    end else if (ram_write) begin
      ram[ram_address] <= ram_value_in;
      ram_value_out    <= ram_value_in;
    end else begin
      ram_value_out <= ram[ram_address];
    end
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    int         port;
    logic [7:0] data;
    int         due;
  } resp_t;
  resp_t q[$];

  // Reference model: port ids 1 = A, 2 = B, 0 = none.
  int         m_owner, m_cnt, m_last;
  logic [7:0] m_mem [32];

  always @(negedge clk) begin
    int         eg;
    logic [4:0] ea;
    logic [7:0] ed, edata;
    logic       ew;
    if (tb_clear) for (int i = 0; i < 32; i++) m_mem[i] = 8'h00;
    eg = 0;
    if (!rst) begin
      if (m_owner == 1 && a_req && !(m_cnt == MAXL && b_req))      eg = 1;
      else if (m_owner == 2 && b_req && !(m_cnt == MAXL && a_req)) eg = 2;
      else if (a_req && b_req) eg = (m_last == 1) ? 2 : 1;
      else if (a_req) eg = 1;
      else if (b_req) eg = 2;
    end
    ea = '0; ed = '0; ew = 1'b0;
    if (eg == 1) begin ea = a_addr; ed = a_wdata; ew = a_we; end
    if (eg == 2) begin ea = b_addr; ed = b_wdata; ew = b_we; end
    chk("a_gnt", a_gnt, int'(eg == 1));
    chk("b_gnt", b_gnt, int'(eg == 2));
    chk("ram_write", ram_write, ew);
    chk("ram_address", ram_address, ea);
    chk("ram_value_in", ram_value_in, ed);
    if (eg != 0) begin
      edata = ew ? ed : m_mem[ea];
      if (ew) m_mem[ea] = ed;
      q.push_back('{eg, edata, cyc + 1});
    end
    case (m_owner)
      0: begin
        if (eg == 1 && a_lock) begin m_owner = 1; m_cnt = 1; end
        else if (eg == 2 && b_lock) begin m_owner = 2; m_cnt = 1; end
      end
      1: begin
        if (!a_req || eg != 1 || !a_lock) begin m_owner = 0; m_cnt = 0; end
        else if (m_cnt < MAXL) m_cnt = m_cnt + 1;
      end
      default: begin
        if (!b_req || eg != 2 || !b_lock) begin m_owner = 0; m_cnt = 0; end
        else if (m_cnt < MAXL) m_cnt = m_cnt + 1;
      end
    endcase
    if (eg != 0) m_last = eg;
    if (rst) begin m_owner = 0; m_cnt = 0; m_last = 2; end
  end

  // Response monitor: pops the scoreboard whenever the DUT presents rvalid.
  always @(negedge clk) begin
    if (a_rvalid) begin
      if (q.size() == 0 || q[0].port != 1 || q[0].due != cyc) begin
        checks++; failures++;
        $display("FAIL a_rvalid: got unexpected response %0h (cycle %0d)", a_rdata, cyc);
      end else begin
        chk("a_rdata", a_rdata, q[0].data);
        void'(q.pop_front());
      end
    end else begin
      chk("a_rdata_idle", a_rdata, 0);
    end
    if (b_rvalid) begin
      if (q.size() == 0 || q[0].port != 2 || q[0].due != cyc) begin
        checks++; failures++;
        $display("FAIL b_rvalid: got unexpected response %0h (cycle %0d)", b_rdata, cyc);
      end else begin
        chk("b_rdata", b_rdata, q[0].data);
        void'(q.pop_front());
      end
    end else begin
      chk("b_rdata_idle", b_rdata, 0);
    end
    if (q.size() > 0 && q[0].due <= cyc) begin
      checks++; failures++;
      $display("FAIL rvalid_missing: got no response, expected port %0d data %0h (cycle %0d)",
               q[0].port, q[0].data, cyc);
      void'(q.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic r, input logic w, input logic [4:0] ad,
                       input logic [7:0] d, input logic l);
    a_req = r; a_we = w; a_addr = ad; a_wdata = d; a_lock = l;
  endtask

  task automatic set_b(input logic r, input logic w, input logic [4:0] ad,
                       input logic [7:0] d, input logic l);
    b_req = r; b_we = w; b_addr = ad; b_wdata = d; b_lock = l;
  endtask

  logic [1:0] seq [10];
  logic       ga, gb;

  initial begin
    rst = 1'b1; tb_clear = 1'b1;
    set_a(0, 0, 0, 0, 0);
    set_b(0, 0, 0, 0, 0);
    repeat (3) step();
    tb_clear = 1'b0; rst = 1'b0;
    step();

    // Write then read back through port A.
    set_a(1, 1, 5'd3, 8'h5A, 0); step();
    set_a(1, 0, 5'd3, 8'h00, 0); step();
    set_a(0, 0, 0, 0, 0); repeat (2) step();

    // Preload, then continuous contention without locks.
    set_a(1, 1, 5'd0, 8'h11, 0); step();
    set_a(1, 1, 5'd31, 8'h22, 0); step();
    set_a(0, 0, 0, 0, 0); step();
    set_a(1, 0, 5'd0, 0, 0); set_b(1, 0, 5'd31, 0, 0);
    repeat (6) step();
    set_a(0, 0, 0, 0, 0); set_b(0, 0, 0, 0, 0); repeat (2) step();

    // Lock held while B idle, then A drops its request.
    set_a(1, 0, 5'd5, 0, 1); repeat (4) step();
    set_a(0, 0, 0, 0, 0); set_b(1, 0, 5'd7, 0, 0); step();
    set_b(0, 0, 0, 0, 0); step();

    // Lock exhausted while B waits.
    set_a(1, 0, 5'd9, 0, 1); set_b(1, 0, 5'd10, 0, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); seq[i] = {a_gnt, b_gnt};
      @(posedge clk); #1;
    end
    for (int i = 0; i < 8; i++) chk("lock_seq_a", seq[i], 2'b10);
    chk("lock_seq_force_b", seq[8], 2'b01);
    chk("lock_seq_a_again", seq[9], 2'b10);
    repeat (2) step();
    set_a(0, 0, 0, 0, 0); set_b(0, 0, 0, 0, 0); repeat (2) step();

    // Reset in the cycle after a B read grant.
    set_b(1, 0, 5'd31, 0, 0);
    @(negedge clk); chk("b_gnt_pre_rst", b_gnt, 1);
    @(posedge clk); #1;
    set_b(0, 0, 0, 0, 0); rst = 1'b1;
    step();
    chk("rst_b_rvalid", b_rvalid, 0);
    chk("rst_b_rdata", b_rdata, 0);
    rst = 1'b0;
    set_a(1, 0, 5'd0, 0, 0); set_b(1, 0, 5'd31, 0, 0);
    @(negedge clk); chk("tie_after_rst", a_gnt, 1);
    @(posedge clk); #1;
    set_a(0, 0, 0, 0, 0); step();
    set_b(0, 0, 0, 0, 0); step();

    // Idle window.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_ram_write", ram_write, 0);
      chk("idle_ram_address", ram_address, 0);
      chk("idle_rvalid", {a_rvalid, b_rvalid}, 0);
      @(posedge clk); #1;
    end

    // Randomized traffic; requests are held stable until granted.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk); ga = a_gnt; gb = b_gnt;
      @(posedge clk); #1;
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 299) == 0) rst = 1'b1;
      if (!a_req || ga) begin
        a_req   = ($urandom_range(0, 3) != 0);
        a_we    = 1'($urandom_range(0, 1));
        a_addr  = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
        a_wdata = 8'($urandom);
        a_lock  = 1'($urandom_range(0, 1));
      end
      if (!b_req || gb) begin
        b_req   = ($urandom_range(0, 2) != 0);
        b_we    = 1'($urandom_range(0, 1));
        b_addr  = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
        b_wdata = 8'($urandom);
        b_lock  = ($urandom_range(0, 3) == 0);
      end
    end
    rst = 1'b0;
    set_a(0, 0, 0, 0, 0); set_b(0, 0, 0, 0, 0);
    repeat (4) step();
    chk("queue_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
